// File: rtl/shot_resolver.sv
// Fire-request resolver for the 10x10 board: pulses the shot line, tracks hits per ship,
// and on a sink pulses the ship plus its 8-neighbour halo before reporting a result code.
module shot_resolver #(
    parameter int NUM_SHIPS = 5,
    parameter int SID_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire_valid,
    output logic                     fire_ready,
    input  logic [3:0]               fire_row,
    input  logic [3:0]               fire_col,
    input  logic [NUM_SHIPS*100-1:0] ship_mask,
    output logic [99:0]              shot,
    output logic [99:0]              is_ship,
    output logic [99:0]              ship_sunk,
    output logic                     result_valid,
    output logic [1:0]               result_code,
    output logic [SID_W-1:0]         sunk_id,
    output logic [SID_W:0]           ships_left,
    output logic                     game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOT, S_EVAL, S_SINK, S_RESULT, S_OVER
    } state_t;

    localparam logic [1:0] RC_MISS = 2'b00;
    localparam logic [1:0] RC_HIT  = 2'b01;
    localparam logic [1:0] RC_SUNK = 2'b10;
    localparam logic [1:0] RC_REJ  = 2'b11;

    state_t                 state_q, state_d;
    logic [6:0]             idx_q, idx_d;
    logic [SID_W-1:0]       owner_q, owner_d;
    logic [99:0]            shot_hist_q, shot_hist_d;
    logic [99:0]            hit_hist_q, hit_hist_d;
    logic [NUM_SHIPS-1:0]   sunk_flags_q, sunk_flags_d;
    logic [SID_W:0]         ships_left_q, ships_left_d;
    logic [SID_W-1:0]       sunk_id_q, sunk_id_d;
    logic [1:0]             result_code_q, result_code_d;

    logic [NUM_SHIPS-1:0][99:0] masks;
    logic [99:0]            sel_mask;
    logic [99:0]            halo;
    logic [SID_W-1:0]       owner_c;
    logic [6:0]             fire_idx;
    logic                   fire_oob;

    assign masks    = ship_mask;
    // Out-of-range coordinates may alias into 0..127; only used once the range check passes.
    assign fire_idx = 7'(fire_row) * 7'd10 + 7'(fire_col);
    assign fire_oob = (fire_row > 4'd9) || (fire_col > 4'd9);
    assign sel_mask = masks[owner_q];

    always_comb begin
        is_ship = '0;
        for (int k = 0; k < NUM_SHIPS; k++) is_ship = is_ship | masks[k];
    end

    // Scan downward so the lowest ship index wins an overlapping cell.
    always_comb begin
        owner_c = '0;
        for (int k = NUM_SHIPS - 1; k >= 0; k--) begin
            if (masks[k][idx_q]) owner_c = SID_W'(k);
        end
    end

    // Halo of the owning ship: each cell ORs its in-bounds 3x3 neighbourhood, no wrap.
    for (genvar gr = 0; gr < 10; gr++) begin : g_row
        for (genvar gc = 0; gc < 10; gc++) begin : g_col
            logic [8:0] nb;
            for (genvar dr = 0; dr < 3; dr++) begin : g_dr
                for (genvar dc = 0; dc < 3; dc++) begin : g_dc
                    if (gr + dr >= 1 && gr + dr <= 10 && gc + dc >= 1 && gc + dc <= 10) begin : g_in
                        assign nb[dr*3+dc] = sel_mask[(gr+dr-1)*10 + (gc+dc-1)];
                    end else begin : g_out
                        assign nb[dr*3+dc] = 1'b0;
                    end
                end
            end
            assign halo[gr*10+gc] = |nb;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        owner_d       = owner_q;
        shot_hist_d   = shot_hist_q;
        hit_hist_d    = hit_hist_q;
        sunk_flags_d  = sunk_flags_q;
        ships_left_d  = ships_left_q;
        sunk_id_d     = sunk_id_q;
        result_code_d = result_code_q;
        case (state_q)
            S_IDLE: begin
                if (fire_valid) begin
                    if (fire_oob || shot_hist_q[fire_idx]) begin
                        result_code_d = RC_REJ;
                        state_d       = S_RESULT;
                    end else begin
                        idx_d   = fire_idx;
                        state_d = S_SHOT;
                    end
                end
            end
            S_SHOT: begin
                shot_hist_d[idx_q] = 1'b1;
                hit_hist_d[idx_q]  = is_ship[idx_q];
                owner_d            = owner_c;
                state_d            = S_EVAL;
            end
            S_EVAL: begin
                if (!hit_hist_q[idx_q]) begin
                    result_code_d = RC_MISS;
                    state_d       = S_RESULT;
                end else if ((sel_mask & ~hit_hist_q) == '0 && !sunk_flags_q[owner_q]) begin
                    state_d = S_SINK;
                end else begin
                    result_code_d = RC_HIT;
                    state_d       = S_RESULT;
                end
            end
            S_SINK: begin
                sunk_flags_d[owner_q] = 1'b1;
                ships_left_d          = ships_left_q - 1'b1;
                sunk_id_d             = owner_q;
                result_code_d         = RC_SUNK;
                state_d               = S_RESULT;
            end
            S_RESULT: state_d = (ships_left_q == '0) ? S_OVER : S_IDLE;
            S_OVER:   state_d = S_OVER;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            owner_q       <= '0;
            shot_hist_q   <= '0;
            hit_hist_q    <= '0;
            sunk_flags_q  <= '0;
            ships_left_q  <= (SID_W+1)'(NUM_SHIPS);
            sunk_id_q     <= '0;
            result_code_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            owner_q       <= owner_d;
            shot_hist_q   <= shot_hist_d;
            hit_hist_q    <= hit_hist_d;
            sunk_flags_q  <= sunk_flags_d;
            ships_left_q  <= ships_left_d;
            sunk_id_q     <= sunk_id_d;
            result_code_q <= result_code_d;
        end
    end

    assign fire_ready   = (state_q == S_IDLE);
    assign shot         = (state_q == S_SHOT) ? (100'(1) << idx_q) : '0;
    assign ship_sunk    = (state_q == S_SINK) ? halo : '0;
    assign result_valid = (state_q == S_RESULT);
    assign result_code  = result_code_q;
    assign sunk_id      = sunk_id_q;
    assign ships_left   = ships_left_q;
    assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: a cell/ship-level game model predicts every output
// each cycle; a few literal halos and codes pin the model itself.
module tb_shot_resolver;

    logic          clk, reset, fire_valid, fire_ready;
    logic [3:0]    fire_row, fire_col;
    logic [499:0]  ship_mask;
    logic [99:0]   shot, is_ship, ship_sunk;
    logic          result_valid, game_over;
    logic [1:0]    result_code;
    logic [2:0]    sunk_id;
    logic [3:0]    ships_left;

    shot_resolver #(.NUM_SHIPS(5), .SID_W(3)) dut (
        .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_row(fire_row), .fire_col(fire_col), .ship_mask(ship_mask),
        .shot(shot), .is_ship(is_ship), .ship_sunk(ship_sunk),
        .result_valid(result_valid), .result_code(result_code), .sunk_id(sunk_id),
        .ships_left(ships_left), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    // expected outputs for the current cycle
    logic [99:0] e_shot, e_sunk, e_is;
    logic        e_rv, e_go, e_ready;
    logic [1:0]  e_code;
    logic [2:0]  e_sid;
    logic [3:0]  e_left;

    // game model
    bit          shot_set[100];
    int          hits[5], size_k[5];
    bit          sunk_m[5];
    int          left;
    int          last_code;
    logic [99:0] last_halo;

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fire_ready", 100'(fire_ready), 100'(e_ready));
            chk("shot", shot, e_shot);
            chk("ship_sunk", ship_sunk, e_sunk);
            chk("is_ship", is_ship, e_is);
            chk("result_valid", 100'(result_valid), 100'(e_rv));
            chk("result_code", 100'(result_code), 100'(e_code));
            chk("sunk_id", 100'(sunk_id), 100'(e_sid));
            chk("ships_left", 100'(ships_left), 100'(e_left));
            chk("game_over", 100'(game_over), 100'(e_go));
        end
    end

    function automatic logic [99:0] cells(input int a, input int b = -1, input int c = -1,
                                          input int d = -1, input int e = -1, input int f = -1,
                                          input int g = -1, input int h = -1);
        logic [99:0] m;
        int l[8];
        m = '0;
        l = '{a, b, c, d, e, f, g, h};
        foreach (l[i]) if (l[i] >= 0) m[l[i]] = 1'b1;
        return m;
    endfunction

    // scatter each ship cell onto its in-bounds neighbours
    function automatic logic [99:0] halo_of(input int k);
        logic [99:0] m;
        m = '0;
        for (int i = 0; i < 100; i++) begin
            if (ship_mask[k*100+i]) begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (i/10+dr >= 0 && i/10+dr <= 9 && i%10+dc >= 0 && i%10+dc <= 9)
                            m[(i/10+dr)*10 + i%10+dc] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic model_reset();
        foreach (shot_set[i]) shot_set[i] = 0;
        for (int k = 0; k < 5; k++) begin
            hits[k] = 0; sunk_m[k] = 0; size_k[k] = 0;
            for (int i = 0; i < 100; i++) size_k[k] += int'(ship_mask[k*100+i]);
        end
        left = 5;
        e_shot = '0; e_sunk = '0; e_rv = 0; e_go = 0; e_ready = 1;
        e_code = 2'b00; e_sid = 3'd0; e_left = 4'd5;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fire_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One fire request; keep leaves fire_valid asserted, abort_cyc asserts reset mid-flight.
    task automatic fire(input int r, input int c, input bit keep, input int abort_cyc);
        int idx, code, lat, k;
        logic [99:0] hl;
        code = 0; k = -1; hl = '0; idx = r*10 + c;
        if (r > 9 || c > 9) code = 3;
        else if (shot_set[idx]) code = 3;
        else begin
            shot_set[idx] = 1;
            for (int j = 4; j >= 0; j--) if (ship_mask[j*100+idx]) k = j;
            if (k < 0) code = 0;
            else begin
                hits[k]++;
                if (hits[k] == size_k[k] && !sunk_m[k]) begin
                    code = 2;
                    hl = halo_of(k);
                end else code = 1;
            end
        end
        lat = (code == 3) ? 1 : (code == 2) ? 4 : 3;
        last_code = code;
        last_halo = hl;
        fire_row = 4'(r); fire_col = 4'(c); fire_valid = 1'b1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(posedge clk); #1;
            if (!keep) fire_valid = 1'b0;
            e_ready = 0;
            e_shot  = (cyc == 1 && code != 3) ? (100'(1) << idx) : '0;
            e_sunk  = (cyc == 3 && code == 2) ? hl : '0;
            e_rv    = (cyc == lat);
            if (cyc == lat) begin
                e_code = 2'(code);
                if (code == 2) begin
                    e_sid = 3'(k); sunk_m[k] = 1; left--; e_left = 4'(left);
                end
            end
            if (cyc == abort_cyc) begin
                @(negedge clk); #2;
                reset = 1'b1; fire_valid = 1'b0;
                model_reset();
                #1;
                chk("abort_sunk_drop", ship_sunk, '0);
                chk("abort_left", 100'(ships_left), 100'(5));
                @(posedge clk); #1 reset = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        e_shot = '0; e_sunk = '0; e_rv = 0;
        if (left == 0) begin e_go = 1; e_ready = 0; end
        else e_ready = 1;
    endtask

    task automatic pin_code(input string nm, input int exp);
        chk(nm, 100'(last_code), 100'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fire_valid = 1'b0; fire_row = '0; fire_col = '0;
        ship_mask = '0;
        ship_mask[0*100+0] = 1'b1; ship_mask[0*100+1] = 1'b1;
        ship_mask[1*100+49] = 1'b1;
        ship_mask[2*100+99] = 1'b1;
        ship_mask[3*100+55] = 1'b1; ship_mask[3*100+56] = 1'b1; ship_mask[3*100+57] = 1'b1;
        ship_mask[4*100+70] = 1'b1; ship_mask[4*100+80] = 1'b1;
        e_is = '0;
        for (int k = 0; k < 5; k++) e_is = e_is | ship_mask[k*100 +: 100];
        chk("is_ship_model", e_is, cells(0, 1, 49, 99, 55, 56, 57, 70) | cells(80));
        model_reset();
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // game 1: miss, hit, sink, rejects, edge halos, then game over
        fire(2, 3, 0, 0);   pin_code("code_miss", 0);
        fire(0, 0, 0, 0);   pin_code("code_hit", 1);
        fire(0, 1, 0, 0);   pin_code("code_sunk0", 2);
        chk("halo_ship0", last_halo, cells(0, 1, 2, 10, 11, 12));
        fire(0, 0, 0, 0);   pin_code("code_repeat", 3);
        fire(10, 0, 0, 0);  pin_code("code_row_oob", 3);
        fire(0, 10, 0, 0);  pin_code("code_col_oob", 3);
        fire(4, 9, 0, 0);
        chk("halo_ship1", last_halo, cells(38, 39, 48, 49, 58, 59));
        fire(9, 9, 0, 0);
        chk("halo_ship2", last_halo, cells(88, 89, 98, 99));
        fire(5, 5, 0, 0);
        fire(5, 6, 0, 0);
        fire(5, 7, 0, 0);
        chk("halo_ship3", last_halo,
            cells(44, 45, 46, 47, 48, 54, 55, 56) | cells(57, 58, 64, 65, 66, 67, 68));
        fire(7, 0, 0, 0);   pin_code("code_hit4", 1);
        fire(8, 0, 0, 0);
        chk("halo_ship4", last_halo, cells(60, 61, 70, 71, 80, 81, 90, 91));
        fire_row = 4'd3; fire_col = 4'd3; fire_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1 fire_valid = 1'b0;
        @(posedge clk); #1;

        // game 2: fire_valid held high across IDLE visits
        do_reset();
        @(posedge clk); #1;
        fire(0, 0, 1, 0);
        fire(3, 3, 1, 0);
        fire(0, 1, 1, 0);   pin_code("code_keep_sunk", 2);
        fire(0, 0, 1, 0);   pin_code("code_keep_rej", 3);
        fire_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // game 3: reset during SINK, then the earlier shot cell is fresh again
        do_reset();
        @(posedge clk); #1;
        fire(0, 0, 0, 0);
        fire(0, 1, 0, 3);
        @(posedge clk); #1;
        fire(0, 0, 0, 0);   pin_code("code_after_abort", 1);
        repeat (2) @(posedge clk);
        #1 chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
